corner_window_sequencer: RTL and testbench

Scheduler for the corner detector's neighbourhood datapath. It accepts the incoming pixel stream and drives the enables of the window shift registers, the write side of the line buffers, and their row rotation. It tracks column/row position per frame and emits one window-valid handshake, with centre coordinates, for every pixel position whose full WIN×WIN neighbourhood lies inside the image. It sits between the camera pixel interface and the window register array / score pipeline.

---
 rtl/corner_seq_pkg.sv | 21 ++
 rtl/corner_seq_pos_counter.sv | 69 ++++++
 rtl/corner_window_sequencer.sv | 156 +++++++++++++++
 tb/tb_corner_window_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corner_seq_pkg.sv
// Shared types and helpers for the corner detector window sequencer.
package corner_seq_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_e;

    localparam int DEF_WIN = 7;
    localparam int HALF    = (DEF_WIN - 1) / 2;

    // Line buffer rotation index width: clog2(WIN-1).
    function automatic int sel_width(input int win);
        return $clog2(win - 1);
    endfunction

    function automatic int half_of(input int win);
        return (win - 1) / 2;
    endfunction

endpackage

// File: rtl/corner_seq_pos_counter.sv
// Column/row/line-buffer-rotation position tracker for the window sequencer.
// restart forces the current beat to (0,0); adv consumes the current position.
module corner_seq_pos_counter
    import corner_seq_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 800,
    parameter int WIN   = 7,
    parameter int COL_W = 11,
    parameter int ROW_W = 10,
    localparam int SEL_W = sel_width(WIN)
) (
    input  logic             c,
    input  logic             rst,
    input  logic             adv,
    input  logic             restart,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic [SEL_W-1:0] cur_sel,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIN - 2);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    always_comb begin
        cur_col = restart ? '0 : col_q;
        cur_row = restart ? '0 : row_q;
        cur_sel = restart ? '0 : sel_q;
        last    = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

        col_d = col_q;
        row_d = row_q;
        sel_d = sel_q;
        if (adv) begin
            if (last) begin
                col_d = '0;
                row_d = '0;
                sel_d = '0;
            end else if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + ROW_W'(1);
                sel_d = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
                sel_d = cur_sel;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/corner_window_sequencer.sv
// Pixel-stream scheduler for the corner detector window/line-buffer datapath.
// Optional statistics counters are built when CORNER_SEQ_STATS_EN is defined.
module corner_window_sequencer
    import corner_seq_pkg::*;
#(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 800,
    parameter int WIN   = 7,
    parameter int COL_W = 11,
    parameter int ROW_W = 10,
    localparam int SEL_W = sel_width(WIN)
) (
    input  logic             c,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic             shift_en,
    output logic             lb_wr_en,
    output logic [COL_W-1:0] lb_addr,
    output logic [SEL_W-1:0] lb_sel,
    output logic             win_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             frame_done,
    output logic             err_sof,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_drops
);

    localparam int WIN_HALF = half_of(WIN);

    seq_state_e       state_q, state_d;
    logic             win_valid_q, win_valid_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic             frame_done_q, frame_done_d;
    logic             err_sof_q, err_sof_d;

    logic             accept, sof_acc, proc, qualify, last;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [SEL_W-1:0] cur_sel;

    // Outside a frame only an SOF beat is processed; everything else is dropped.
    assign in_ready = !win_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sof_acc  = accept && in_sof;
    assign proc     = accept && (in_sof || (state_q == ACTIVE));

    corner_seq_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .c       (c),
        .rst     (rst),
        .adv     (proc),
        .restart (sof_acc),
        .cur_col (cur_col),
        .cur_row (cur_row),
        .cur_sel (cur_sel),
        .last    (last)
    );

    assign qualify = proc && (cur_col >= COL_W'(WIN - 1)) && (cur_row >= ROW_W'(WIN - 1));

    always_comb begin
        state_d      = state_q;
        win_valid_d  = win_valid_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        frame_done_d = proc && last;
        err_sof_d    = sof_acc && (state_q == ACTIVE);

        if (proc) begin
            state_d = last ? IDLE : ACTIVE;
        end

        if (qualify) begin
            win_valid_d = 1'b1;
            win_col_d   = cur_col - COL_W'(WIN_HALF);
            win_row_d   = cur_row - ROW_W'(WIN_HALF);
        end else if (out_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q      <= IDLE;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign shift_en   = proc;
    assign lb_wr_en   = proc;
    assign lb_addr    = cur_col;
    assign lb_sel     = cur_sel;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

`ifdef CORNER_SEQ_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d;
    logic [15:0] stat_drops_q, stat_drops_d;
    logic        drop;

    assign drop = accept && !in_sof && (state_q == IDLE);

    // Saturating event counters.
    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_drops_d  = stat_drops_q;
        if (frame_done_q && (stat_frames_q != 16'hFFFF)) begin
            stat_frames_d = stat_frames_q + 16'd1;
        end
        if (drop && (stat_drops_q != 16'hFFFF)) begin
            stat_drops_d = stat_drops_q + 16'd1;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            stat_frames_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_drops_q  <= stat_drops_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_drops  = stat_drops_q;
`else
    assign stat_frames = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_corner_window_sequencer.sv
// Scoreboard bench for corner_window_sequencer on an 8x6 image with a 3x3 window.
module tb_corner_window_sequencer;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int COL_W = 4;
    localparam int ROW_W = 3;

    logic             c = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready, shift_en, lb_wr_en, win_valid, frame_done, err_sof;
    logic [COL_W-1:0] lb_addr, win_col;
    logic [0:0]       lb_sel;
    logic [ROW_W-1:0] win_row;
    logic [15:0]      stat_frames, stat_drops;

    always #5 c = ~c;

    corner_window_sequencer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) dut (
        .c           (c),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .shift_en    (shift_en),
        .lb_wr_en    (lb_wr_en),
        .lb_addr     (lb_addr),
        .lb_sel      (lb_sel),
        .win_valid   (win_valid),
        .out_ready   (out_ready),
        .win_col     (win_col),
        .win_row     (win_row),
        .frame_done  (frame_done),
        .err_sof     (err_sof),
        .stat_frames (stat_frames),
        .stat_drops  (stat_drops)
    );

    typedef struct {
        int col;
        int row;
    } win_t;

    win_t exp_q[$];
    win_t mon_w;
    int   fd_cyc[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int win_seen = 0;
    int err_seen = 0;

    bit fd_next = 0, fd_cur = 0;
    bit err_next = 0, err_cur = 0;
    bit wv_next = 0, wv_cur = 0;
    bit strict = 1;

    bit m_active = 0;
    int m_col = 0, m_row = 0, m_drops = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge c) begin
        cyc++;
        fd_cur  = fd_next;  fd_next  = 0;
        err_cur = err_next; err_next = 0;
        wv_cur  = wv_next;  wv_next  = 0;
    end

    // Monitor: pulse timing and window scoreboard, sampled on the falling edge.
    always @(negedge c) begin
        if (fd_cur || frame_done) begin
            check("frame_done", int'(frame_done), int'(fd_cur));
            if (frame_done) fd_cyc.push_back(cyc);
        end
        if (err_cur || err_sof) begin
            check("err_sof", int'(err_sof), int'(err_cur));
            if (err_sof) err_seen++;
        end
        if (strict && (wv_cur || win_valid)) check("win_valid_timing", int'(win_valid), int'(wv_cur));
        if (win_valid && out_ready) begin
            win_seen++;
            if (exp_q.size() == 0) check("win_unexpected", 1, 0);
            else begin
                mon_w = exp_q.pop_front();
                check("win_col", int'(win_col), mon_w.col);
                check("win_row", int'(win_row), mon_w.row);
            end
        end
    end

    task automatic send_pixel(input bit sof);
        int   n;
        win_t w;
        n = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        @(negedge c);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge c);
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            return;
        end
        if (sof) begin
            if (m_active) err_next = 1;
            m_active = 1;
            m_col = 0;
            m_row = 0;
        end
        if (!m_active) begin
            check("shift_en_idle", int'(shift_en), 0);
            check("lb_wr_en_idle", int'(lb_wr_en), 0);
            m_drops++;
        end else begin
            check("shift_en", int'(shift_en), 1);
            check("lb_wr_en", int'(lb_wr_en), 1);
            check("lb_addr", int'(lb_addr), m_col);
            check("lb_sel", int'(lb_sel), m_row % (WIN - 1));
            if (m_col >= WIN - 1 && m_row >= WIN - 1) begin
                w.col = m_col - (WIN - 1) / 2;
                w.row = m_row - (WIN - 1) / 2;
                exp_q.push_back(w);
                wv_next = 1;
            end
            if (m_col == IMG_W - 1 && m_row == IMG_H - 1) begin
                fd_next  = 1;
                m_active = 0;
                m_col    = 0;
                m_row    = 0;
            end else if (m_col == IMG_W - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
        @(posedge c);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame();
        send_pixel(1'b1);
        for (int i = 1; i < IMG_W * IMG_H; i++) send_pixel(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        @(posedge c);
        #1;
        rst = 1'b0;
        m_active = 0;
        m_col    = 0;
        m_row    = 0;
        m_drops  = 0;
        exp_q.delete();
        fd_cyc.delete();
        err_seen = 0;
        @(negedge c);
        check("rst_win_valid", int'(win_valid), 0);
        check("rst_win_col", int'(win_col), 0);
        check("rst_win_row", int'(win_row), 0);
        check("rst_lb_sel", int'(lb_sel), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err_sof", int'(err_sof), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_shift_en", int'(shift_en), 0);
        check("rst_stat_frames", int'(stat_frames), 0);
        check("rst_stat_drops", int'(stat_drops), 0);
        @(posedge c);
        #1;
    endtask

    task automatic check_stats(input string tag, input int frames, input int drops);
`ifdef CORNER_SEQ_STATS_EN
        check({tag, "_stat_frames"}, int'(stat_frames), frames);
        check({tag, "_stat_drops"}, int'(stat_drops), drops);
`else
        check({tag, "_stat_frames"}, int'(stat_frames), 0);
        check({tag, "_stat_drops"}, int'(stat_drops), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Plain frame.
        do_reset();
        base = win_seen;
        send_frame();
        idle(3);
        check("plain_windows", win_seen - base, 24);
        check("plain_frame_done", fd_cyc.size(), 1);
        check("plain_queue_empty", exp_q.size(), 0);
        check_stats("plain", 1, 0);

        // Backpressure after the first window.
        do_reset();
        strict = 0;
        base = win_seen;
        send_pixel(1'b1);
        for (int i = 1; i <= 18; i++) send_pixel(1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (4) begin
            @(negedge c);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_shift_en", int'(shift_en), 0);
            check("bp_win_valid", int'(win_valid), 1);
            check("bp_win_col", int'(win_col), 1);
            check("bp_win_row", int'(win_row), 1);
        end
        @(posedge c);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 19; i < IMG_W * IMG_H; i++) send_pixel(1'b0);
        idle(3);
        strict = 1;
        check("bp_windows", win_seen - base, 24);
        check("bp_frame_done", fd_cyc.size(), 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Garbage before SOF.
        do_reset();
        base = win_seen;
        repeat (5) send_pixel(1'b0);
        send_frame();
        idle(3);
        check("pre_windows", win_seen - base, 24);
        check("pre_frame_done", fd_cyc.size(), 1);
        check_stats("pre", 1, 5);

        // SOF in the middle of a frame.
        do_reset();
        base = win_seen;
        send_pixel(1'b1);
        for (int i = 1; i < 20; i++) send_pixel(1'b0);
        send_frame();
        idle(3);
        check("midsof_windows", win_seen - base, 26);
        check("midsof_err", err_seen, 1);
        check("midsof_frame_done", fd_cyc.size(), 1);
        check("midsof_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a frame.
        do_reset();
        send_pixel(1'b1);
        for (int i = 1; i < 30; i++) send_pixel(1'b0);
        do_reset();
        base = win_seen;
        send_pixel(1'b0);
        send_frame();
        idle(3);
        check("rst_mid_windows", win_seen - base, 24);
        check("rst_mid_frame_done", fd_cyc.size(), 1);
        check_stats("rst_mid", 1, 1);

        // Back-to-back frames.
        do_reset();
        base = win_seen;
        send_frame();
        send_frame();
        idle(3);
        check("b2b_windows", win_seen - base, 48);
        check("b2b_frame_done", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2) check("b2b_spacing", fd_cyc[1] - fd_cyc[0], 48);
        check_stats("b2b", 2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
